// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment display driver.
// A binary value is captured on load and converted to BCD by a sequential shift-add-3 engine.
// The display BCD register only changes once the conversion is complete.
// Digits are scanned one slot at a time. Leading-zero blanking, per-digit blink and an
// overflow dash pattern are applied when each digit's segments are registered.
module seg_scan_display #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned NUM_W     = 27,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_W-1:0]  num,
  input  logic              load,
  output logic              busy,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] blink_mask,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [7:0]        an
);

  localparam int unsigned BcdW = 4 * DIGITS + 4;
  localparam int unsigned CntW = $clog2(NUM_W);
  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned BlkW = $clog2(BLINK_DIV + 1);
  localparam int unsigned IdxW = 3;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b1111110;

  // Conversion state
  logic [NUM_W-1:0]    bin_q;
  logic [BcdW-1:0]     scratch_q;
  logic [CntW-1:0]     cnt_q;
  logic                busy_q;
  logic                carry_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                ovf_q;

  // Scan state
  logic [DivW-1:0]     div_q;
  logic [IdxW-1:0]     idx_q;
  logic [BlkW-1:0]     slot_q;
  logic                phase_q;  // 1 = blink-off phase
  logic [6:0]          seg_q, seg_d;
  logic [7:0]          an_q, an_d;

  logic [BcdW-1:0]     adj;
  logic [BcdW-1:0]     shifted;
  logic                carry_out;
  logic                last_iter;
  logic [3:0]          nib;
  logic                mask_bit;
  logic                hi_nonzero;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift in the next binary MSB
  always_comb begin
    adj = scratch_q;
    for (int n = 0; n <= int'(DIGITS); n++) begin
      if (scratch_q[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
      end
    end
    shifted   = {adj[BcdW-2:0], bin_q[NUM_W-1]};
    carry_out = adj[BcdW-1];
    last_iter = (cnt_q == CntW'(NUM_W - 1));
  end

  // Load capture, sequential conversion and atomic commit to the display register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      carry_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (busy_q) begin
      bin_q     <= {bin_q[NUM_W-2:0], 1'b0};
      scratch_q <= shifted;
      carry_q   <= carry_q | carry_out;
      cnt_q     <= cnt_q + 1'b1;
      if (last_iter) begin
        busy_q <= 1'b0;
        bcd_q  <= shifted[4*DIGITS-1:0];
        // Anything in the spare top nibble, or carried past it, means the value did not fit
        ovf_q  <= carry_q | carry_out | (|shifted[BcdW-1 -: 4]);
      end
    end else if (load) begin
      bin_q     <= num;
      scratch_q <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b1;
    end
  end

  // Slot divider, digit index and blink phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      slot_q  <= '0;
      phase_q <= 1'b0;
    end else if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      if (slot_q == BlkW'(BLINK_DIV - 1)) begin
        slot_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        slot_q <= slot_q + 1'b1;
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Segment and anode selection for the current digit, in priority order
  always_comb begin
    nib        = 4'd0;
    mask_bit   = 1'b0;
    hi_nonzero = 1'b0;
    an_d       = 8'hFF;
    for (int n = 0; n < int'(DIGITS); n++) begin
      if (idx_q == IdxW'(n)) begin
        nib      = bcd_q[4*n +: 4];
        mask_bit = blink_mask[n];
        an_d[n]  = 1'b0;
      end
      if (IdxW'(n) >= idx_q && bcd_q[4*n +: 4] != 4'd0) begin
        hi_nonzero = 1'b1;
      end
    end
    if (ovf_q) begin
      seg_d = (phase_q && mask_bit) ? SegBlank : SegDash;
    end else if (phase_q && mask_bit) begin
      seg_d = SegBlank;
    end else if (blank_lz && idx_q != '0 && !hi_nonzero) begin
      seg_d = SegBlank;
    end else begin
      seg_d = seg_decode(nib);
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= SegBlank;
      an_q  <= 8'hFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display. Loaded values are queued when driven and popped when
// busy falls. Displayed digits are predicted from decimal arithmetic on the popped value.
// The scan position is derived from the number of clock edges since reset release.
module tb_seg_scan_display;

  localparam int unsigned D = 4;
  localparam int unsigned W = 14;
  localparam int unsigned S = 4;
  localparam int unsigned B = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] num = '0;
  logic         load = 1'b0;
  logic         busy;
  logic         blank_lz = 1'b0;
  logic [D-1:0] blink_mask = '0;
  logic         overflow;
  logic [6:0]   seg;
  logic [7:0]   an;

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned k;            // clock edges since reset release
  int unsigned sb_q[$];
  int unsigned cur_v = 0;

  seg_scan_display #(
    .DIGITS   (D),
    .NUM_W    (W),
    .SCAN_DIV (S),
    .BLINK_DIV(B)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .num       (num),
    .load      (load),
    .busy      (busy),
    .blank_lz  (blank_lz),
    .blink_mask(blink_mask),
    .overflow  (overflow),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dec(input int unsigned d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned v, input int unsigned i, input bit off);
    int unsigned p = 1;
    for (int j = 0; j < int'(i); j++) p = p * 10;
    if (v >= 10000) return (off && blink_mask[i]) ? 7'b1111111 : 7'b1111110;
    if (off && blink_mask[i]) return 7'b1111111;
    if (blank_lz && i > 0 && v < p) return 7'b1111111;
    return dec((v / p) % 10);
  endfunction

  // Compare an and seg at each negedge for the given number of cycles
  task automatic check_display(input string tag, input int unsigned cycles);
    int unsigned slot, i;
    bit          off;
    logic [7:0]  an_exp;
    logic [6:0]  seg_exp;
    for (int c = 0; c < int'(cycles); c++) begin
      @(negedge clk);
      slot    = (k - 1) / S;
      i       = slot % D;
      off     = ((slot / B) % 2) == 1;
      an_exp  = 8'hFF;
      an_exp[i] = 1'b0;
      seg_exp = exp_seg(cur_v, i, off);
      check({tag, "_an"}, 32'(an), 32'(an_exp));
      check({tag, "_seg"}, 32'(seg), 32'(seg_exp));
    end
  endtask

  // Pulse load with v; optionally re-present extra_v on load for 'hold' cycles while busy
  task automatic do_load(input int unsigned v, input int unsigned extra_v, input int hold);
    int n;
    @(negedge clk);
    num  = W'(v);
    load = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n <= hold) begin
        load = 1'b1;
        num  = W'(extra_v);
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("busy_len", 32'(n), 32'(W));
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(0), 32'(1));
    end else begin
      cur_v = sb_q.pop_front();
      check("overflow", 32'(overflow), 32'(cur_v >= 10000));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hFF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cur_v   = 0;
    check_display("post_reset", 16);

    do_load(1234, 0, 0);
    check_display("v1234", 16);

    blank_lz = 1'b1;
    do_load(7, 0, 0);
    check_display("lz7", 16);
    do_load(0, 0, 0);
    check_display("lz0", 16);
    blank_lz = 1'b0;

    do_load(10000, 0, 0);
    check_display("ovf", 16);
    do_load(9999, 0, 0);
    check_display("v9999", 16);

    // Second value presented only while busy must never be accepted
    do_load(1234, 5678, 5);
    check_display("ignored", 16);
    check("sb_left", 32'(sb_q.size()), 32'(0));

    // With these parameters digit 0 always lands in an on phase, digit 2 in an off phase
    blink_mask = 4'b0101;
    check_display("blink", 32);
    blink_mask = 4'b0000;

    // Reset mid-conversion without a clock edge
    @(negedge clk);
    num  = W'(4321);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'(0));
    check("mid_seg", 32'(seg), 32'h7F);
    check("mid_an", 32'(an), 32'hFF);
    check("mid_ovf", 32'(overflow), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    cur_v   = 0;
    check_display("after_mid", 16);
    check("after_busy", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
